// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding, the
// coin_sel denomination encoding, coin face values and the coin count.
// No ports; imported by the interface, the stock counter and the top.
package dispenser_pkg;

  localparam int NUM_COINS = 3;
  localparam int AMT_W     = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_e;

  // Lower index means larger coin, so a scan from index 0 upward is
  // largest-first.
  typedef enum logic [1:0] {
    SEL_500  = 2'd0,
    SEL_100  = 2'd1,
    SEL_50   = 2'd2,
    SEL_NONE = 2'd3
  } coin_sel_e;

  localparam logic [AMT_W-1:0] COIN_VAL_500 = 12'd500;
  localparam logic [AMT_W-1:0] COIN_VAL_100 = 12'd100;
  localparam logic [AMT_W-1:0] COIN_VAL_50  = 12'd50;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_500: coin_value = COIN_VAL_500;
      SEL_100: coin_value = COIN_VAL_100;
      SEL_50:  coin_value = COIN_VAL_50;
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request / coin-ejector bundle of the change dispenser.
//   start, amount, restock : request side, driven by the master
//   coin_ack               : ejector release, driven by the master
//   coin_valid, coin_sel   : coin ejection request, driven by the slave
//   remaining, busy        : progress status, driven by the slave
//   done, error            : one-cycle completion pulses, driven by the slave
//   stock_empty            : per-denomination empty flags, driven by the slave
interface change_dispenser_if;
  import dispenser_pkg::*;

  logic                 start;
  logic [AMT_W-1:0]     amount;
  logic                 restock;
  logic                 coin_ack;
  logic                 coin_valid;
  logic [1:0]           coin_sel;
  logic [AMT_W-1:0]     remaining;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [NUM_COINS-1:0] stock_empty;

  modport master (
    output start, amount, restock, coin_ack,
    input  coin_valid, coin_sel, remaining, busy, done, error, stock_empty
  );

  modport slave (
    input  start, amount, restock, coin_ack,
    output coin_valid, coin_sel, remaining, busy, done, error, stock_empty
  );

endinterface

// File: rtl/change_dispenser_coin_stock.sv
// coin_stock: 4-bit coin counter for one denomination.
//   clk, rst : clock, synchronous active-high reset (reloads INIT)
//   load_i   : restock, reloads INIT
//   dec_i    : one coin dispensed
//   empty_o  : counter is zero
module coin_stock #(
  parameter logic [3:0] INIT = 4'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic empty_o
);

  logic [3:0] cnt_q;

  // The zero guard is a backstop; selection never picks an empty stock.
  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      cnt_q <= INIT;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign empty_o = (cnt_q == 4'd0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out an amount as 500/100/50 coins, largest coin
// first, one coin per ejector handshake, from per-denomination stocks.
//   clk, rst : clock, synchronous active-high reset
//   bus      : change_dispenser_if slave modport (request, ejector, status)
module change_dispenser
  import dispenser_pkg::*;
#(
  parameter logic [3:0] STOCK_INIT = 4'd8
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  state_e               state_q, state_d;
  logic [AMT_W-1:0]     remaining_q, remaining_d;
  logic [1:0]           sel_q, sel_d;
  logic [NUM_COINS-1:0] empty;
  logic [NUM_COINS-1:0] dec;
  logic                 load;
  logic                 found;
  logic [1:0]           pick;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_stock
    coin_stock #(.INIT(STOCK_INIT)) u_stock (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .dec_i   (dec[g]),
      .empty_o (empty[g])
    );
  end

  // Scan smallest coin to largest so the last hit is the largest coin that
  // both fits the remainder and is still in stock.
  always_comb begin
    found = 1'b0;
    pick  = SEL_NONE;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (!empty[i] && (coin_value(2'(i)) <= remaining_q)) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sel_d       = sel_q;
    dec         = '0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          remaining_d = bus.amount;
          state_d     = (bus.amount == '0) ? DONE : SELECT;
        end else if (bus.restock) begin
          load = 1'b1;
        end
      end
      SELECT: begin
        if (found) begin
          sel_d   = pick;
          state_d = EJECT;
        end else begin
          state_d = ERROR;
        end
      end
      EJECT: begin
        // Leaving EJECT on the ack edge makes a held ack count once.
        if (bus.coin_ack) begin
          remaining_d = remaining_q - coin_value(sel_q);
          dec         = NUM_COINS'(1) << sel_q;
          state_d     = (remaining_d == '0) ? DONE : SELECT;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      sel_q       <= SEL_500;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
    end
  end

  assign bus.coin_valid  = (state_q == EJECT);
  assign bus.coin_sel    = sel_q;
  assign bus.remaining   = remaining_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.error       = (state_q == ERROR);
  assign bus.stock_empty = empty;

endmodule
